// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: base opcodes, immediate formats and the
// per-opcode control summary used by the decode stage.
package rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4,
        IMM_R = 3'd5
    } imm_type_e;

    typedef struct packed {
        logic      legal;
        logic      uses_rs1;
        logic      uses_rs2;
        logic      writes_rd;
        imm_type_e imm_type;
    } dec_ctrl_t;

    // Unknown opcodes read nothing and write nothing, so they never interlock.
    function automatic dec_ctrl_t decode_opcode(input logic [6:0] opcode);
        dec_ctrl_t c;
        c = '{legal: 1'b1, uses_rs1: 1'b1, uses_rs2: 1'b0, writes_rd: 1'b1, imm_type: IMM_I};
        case (opcode)
            OPC_LUI:    begin c.uses_rs1 = 1'b0; c.imm_type = IMM_U; end
            OPC_AUIPC:  begin c.uses_rs1 = 1'b0; c.imm_type = IMM_U; end
            OPC_JAL:    begin c.uses_rs1 = 1'b0; c.imm_type = IMM_J; end
            OPC_JALR:   c.imm_type = IMM_I;
            OPC_BRANCH: begin c.uses_rs2 = 1'b1; c.writes_rd = 1'b0; c.imm_type = IMM_B; end
            OPC_LOAD:   c.imm_type = IMM_I;
            OPC_STORE:  begin c.uses_rs2 = 1'b1; c.writes_rd = 1'b0; c.imm_type = IMM_S; end
            OPC_OP_IMM: c.imm_type = IMM_I;
            OPC_OP:     begin c.uses_rs2 = 1'b1; c.imm_type = IMM_R; end
            OPC_FENCE:  c.writes_rd = 1'b0;
            OPC_SYSTEM: c.writes_rd = 1'b0;
            default:    c = '{legal: 1'b0, uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b0, imm_type: IMM_R};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate generator; selects the bit scatter of the
// instruction's format and sign-extends to XLEN.
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:7]     instr,
    input  imm_type_e       imm_type,
    output logic [XLEN-1:0] imm
);

    // Reassemble the immediate for the requested format.
    always_comb begin
        imm = 32'd0;
        case (imm_type)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'd0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes one instruction per cycle into the ID/EX register
// and interlocks RAW/WAW hazards with a busy scoreboard. Optional macro
// DECODE_WB_BYPASS_EN forwards same-cycle writeback data into the operands.
module decode_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_val,
    output logic [XLEN-1:0] out_rs2_val,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic            out_funct7_b5,
    output logic            out_illegal
);

    logic [4:0]      rs1_s, rs2_s, rd_s;
    dec_ctrl_t       ctrl_s;
    logic            writes_rd_s;
    logic [XLEN-1:0] imm_s;
    logic            wb_hit1_s, wb_hit2_s;
    logic            hazard_s, in_ready_s, accept_s;
    logic [XLEN-1:0] rs1_val_s, rs2_val_s;
    logic [31:0]     busy_r, busy_nxt_s, clr_wb_s, clr_fl_s, set_s;

    logic            out_valid_r, out_rd_we_r, out_funct7_b5_r, out_illegal_r;
    logic [PC_W-1:0] out_pc_r;
    logic [XLEN-1:0] out_rs1_val_r, out_rs2_val_r, out_imm_r;
    logic [4:0]      out_rd_r;
    logic [6:0]      out_opcode_r;
    logic [2:0]      out_funct3_r;

    assign rs1_s       = in_instr[19:15];
    assign rs2_s       = in_instr[24:20];
    assign rd_s        = in_instr[11:7];
    assign ctrl_s      = decode_opcode(in_instr[6:0]);
    assign writes_rd_s = ctrl_s.writes_rd & (rd_s != 5'd0);
    assign rs1_addr    = rs1_s;
    assign rs2_addr    = rs2_s;

    imm_gen u_imm_gen (
        .instr    (in_instr[31:7]),
        .imm_type (ctrl_s.imm_type),
        .imm      (imm_s)
    );

    assign wb_hit1_s = wb_we & (wb_rd != 5'd0) & ctrl_s.uses_rs1 & (wb_rd == rs1_s);
    assign wb_hit2_s = wb_we & (wb_rd != 5'd0) & ctrl_s.uses_rs2 & (wb_rd == rs2_s);

`ifdef DECODE_WB_BYPASS_EN
    assign rs1_val_s = wb_hit1_s ? wb_data : rs1_data;
    assign rs2_val_s = wb_hit2_s ? wb_data : rs2_data;
    assign hazard_s  = (ctrl_s.uses_rs1 & busy_r[rs1_s] & ~wb_hit1_s)
                     | (ctrl_s.uses_rs2 & busy_r[rs2_s] & ~wb_hit2_s)
                     | (writes_rd_s & busy_r[rd_s]);
`else
    // The register file only reflects a commit after the edge, so wait it out.
    logic unused_wb_data_s;
    assign unused_wb_data_s = ^wb_data;
    assign rs1_val_s = rs1_data;
    assign rs2_val_s = rs2_data;
    assign hazard_s  = (ctrl_s.uses_rs1 & busy_r[rs1_s])
                     | (ctrl_s.uses_rs2 & busy_r[rs2_s])
                     | (writes_rd_s & busy_r[rd_s])
                     | wb_hit1_s | wb_hit2_s;
`endif

    assign in_ready_s = ~rst & ~hazard_s & (~out_valid_r | out_ready) & ~flush;
    assign accept_s   = in_valid & in_ready_s;
    assign in_ready   = in_ready_s;

    // Set beats clear on the same index; x0 is forced idle.
    assign clr_wb_s   = (wb_we && (wb_rd != 5'd0)) ? (32'd1 << wb_rd) : 32'd0;
    assign clr_fl_s   = (flush && out_valid_r && out_rd_we_r) ? (32'd1 << out_rd_r) : 32'd0;
    assign set_s      = (accept_s && writes_rd_s) ? (32'd1 << rd_s) : 32'd0;
    assign busy_nxt_s = ((busy_r & ~clr_wb_s & ~clr_fl_s) | set_s) & ~32'd1;

    // Busy scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 32'd0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // ID/EX pipeline register; fields hold whenever nothing new is loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r     <= 1'b0;
            out_pc_r        <= '0;
            out_rs1_val_r   <= '0;
            out_rs2_val_r   <= '0;
            out_imm_r       <= '0;
            out_rd_r        <= 5'd0;
            out_rd_we_r     <= 1'b0;
            out_opcode_r    <= 7'd0;
            out_funct3_r    <= 3'd0;
            out_funct7_b5_r <= 1'b0;
            out_illegal_r   <= 1'b0;
        end else if (flush) begin
            out_valid_r     <= 1'b0;
        end else if (accept_s) begin
            out_valid_r     <= 1'b1;
            out_pc_r        <= in_pc;
            out_rs1_val_r   <= rs1_val_s;
            out_rs2_val_r   <= rs2_val_s;
            out_imm_r       <= imm_s;
            out_rd_r        <= rd_s;
            out_rd_we_r     <= writes_rd_s;
            out_opcode_r    <= in_instr[6:0];
            out_funct3_r    <= in_instr[14:12];
            out_funct7_b5_r <= in_instr[30];
            out_illegal_r   <= ~ctrl_s.legal;
        end else if (out_ready) begin
            out_valid_r     <= 1'b0;
        end
    end

    assign out_valid     = out_valid_r;
    assign out_pc        = out_pc_r;
    assign out_rs1_val   = out_rs1_val_r;
    assign out_rs2_val   = out_rs2_val_r;
    assign out_imm       = out_imm_r;
    assign out_rd        = out_rd_r;
    assign out_rd_we     = out_rd_we_r;
    assign out_opcode    = out_opcode_r;
    assign out_funct3    = out_funct3_r;
    assign out_funct7_b5 = out_funct7_b5_r;
    assign out_illegal   = out_illegal_r;

endmodule
